// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM encoding and default widths.
package cpu_pkg;

   localparam int         DWIDTH_DEF  = 16;
   localparam int         AWIDTH_DEF  = 12;
   localparam logic [3:0] HALT_OP_DEF = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      HALT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/ifetch_pc.sv
// Program counter for instruction fetch: reset/redirect/increment mux plus the
// stale flag marking an in-flight irom response that a redirect has orphaned.
module ifetch_pc
   import cpu_pkg::*;
#(
   parameter int                AWIDTH   = AWIDTH_DEF,
   parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_pc,
   input  logic              pc_inc,
   input  logic              stale_set,
   input  logic              stale_clr,
   output logic [AWIDTH-1:0] pc,
   output logic              stale
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else if (pc_inc) begin
         pc <= pc + AWIDTH'(1);
      end
   end

   // A response arriving always retires staleness, even on a redirect in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         stale <= 1'b0;
      end else if (stale_clr) begin
         stale <= 1'b0;
      end else if (stale_set) begin
         stale <= 1'b1;
      end
   end

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction-fetch initiator: drives irom requests, buffers one instruction for decode.
// Optional halt-opcode detection is enabled by defining IFETCH_HALT_EN.
module cpu_ifetch
   import cpu_pkg::*;
#(
   parameter int                DWIDTH   = DWIDTH_DEF,
   parameter int                AWIDTH   = AWIDTH_DEF,
   parameter logic [AWIDTH-1:0] RESET_PC = '0
`ifdef IFETCH_HALT_EN
   ,
   parameter logic [3:0]        HALT_OP  = HALT_OP_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_in,
   output logic [AWIDTH-1:0] rom_addr,
   output logic              rom_ready,
   input  logic [DWIDTH-1:0] rom_dout,
   input  logic              rom_valid,
   input  logic              redirect,
   input  logic [AWIDTH-1:0] redirect_pc,
   output logic [DWIDTH-1:0] ins,
   output logic [AWIDTH-1:0] ins_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic              halted
);

   fetch_state_t      state;
   logic [AWIDTH-1:0] pc;
   logic              stale;
   logic              in_req;
   logic              rsp;
   logic              pc_inc;
   logic              stale_set;
   logic              stale_clr;
   logic              accept;

   assign in_req    = (state == REQ);
   assign rsp       = in_req && rom_valid;
   assign pc_inc    = rsp && !stale && !redirect;
   assign stale_set = in_req && !rom_valid && redirect;
   assign stale_clr = rsp;
   assign accept    = ins_valid && ins_ready;

   ifetch_pc #(
      .AWIDTH   (AWIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .pc_inc      (pc_inc),
      .stale_set   (stale_set),
      .stale_clr   (stale_clr),
      .pc          (pc),
      .stale       (stale)
   );

`ifdef IFETCH_HALT_EN
   function automatic logic is_halt(input logic [DWIDTH-1:0] word);
      return word[DWIDTH-1 -: 4] == HALT_OP;
   endfunction
`else
   assign halted = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rom_ready <= 1'b0;
         rom_addr  <= RESET_PC;
         ins       <= '0;
         ins_pc    <= '0;
         ins_valid <= 1'b0;
`ifdef IFETCH_HALT_EN
         halted    <= 1'b0;
`endif
      end else if (redirect) begin
         ins_valid <= 1'b0;
`ifdef IFETCH_HALT_EN
         halted    <= 1'b0;
`endif
         // Without a response this cycle the old request stays on the bus; the PC block marks it stale.
         case (state)
            REQ: begin
               if (rom_valid) rom_addr <= redirect_pc;
            end
            HOLD, HALT: begin
               state     <= REQ;
               rom_ready <= 1'b1;
               rom_addr  <= redirect_pc;
            end
            default: ;
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (en_in) begin
                  state     <= REQ;
                  rom_ready <= 1'b1;
                  rom_addr  <= pc;
               end
            end
            REQ: begin
               if (rom_valid) begin
                  if (stale) begin
                     rom_addr <= pc;
                  end else begin
                     ins       <= rom_dout;
                     ins_pc    <= pc;
                     ins_valid <= 1'b1;
                     rom_ready <= 1'b0;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (accept) begin
                  ins_valid <= 1'b0;
`ifdef IFETCH_HALT_EN
                  if (is_halt(ins)) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else
`endif
                  if (en_in) begin
                     state     <= REQ;
                     rom_ready <= 1'b1;
                     rom_addr  <= pc;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Self-checking bench for cpu_ifetch with a behavioural irom responder and a scoreboard.
module tb_cpu_ifetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_in = 1'b0;
   logic [11:0] rom_addr;
   logic        rom_ready;
   logic [15:0] rom_dout = '0;
   logic        rom_valid = 1'b0;
   logic        redirect = 1'b0;
   logic [11:0] redirect_pc = '0;
   logic [15:0] ins;
   logic [11:0] ins_pc;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic        halted;

   logic [15:0] mem [0:4095];
   int          lat = 1;
   int          errs = 0;
   int          checks = 0;
   int          cyc = 0;

   typedef struct {
      logic [15:0] i;
      logic [11:0] p;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   cpu_ifetch #(
      .DWIDTH   (16),
      .AWIDTH   (12),
      .RESET_PC (12'h000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en_in       (en_in),
      .rom_addr    (rom_addr),
      .rom_ready   (rom_ready),
      .rom_dout    (rom_dout),
      .rom_valid   (rom_valid),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ins         (ins),
      .ins_pc      (ins_pc),
      .ins_valid   (ins_valid),
      .ins_ready   (ins_ready),
      .halted      (halted)
   );

   // irom responder: samples a request, answers lat cycles later with a one-cycle pulse.
   initial begin
      logic        busy;
      logic [11:0] req_addr;
      int          cnt;
      busy = 1'b0;
      req_addr = '0;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
            rom_valid = 1'b0;
         end else begin
            if (rom_valid) begin
               rom_valid = 1'b0;
               busy = 1'b0;
            end
            if (busy) begin
               cnt--;
               if (cnt == 0) begin
                  rom_valid = 1'b1;
                  rom_dout = mem[req_addr];
               end
            end else if (rom_ready) begin
               busy = 1'b1;
               req_addr = rom_addr;
               cnt = lat;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #2;
      cyc++;
      redirect = 1'b0;
   endtask

   task automatic push_exp(input logic [11:0] a);
      exp_t e;
      e.i = mem[a];
      e.p = a;
      sbq.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en_in = 1'b0;
      ins_ready = 1'b0;
      redirect = 1'b0;
      sbq.delete();
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (rom_ready !== 1'b0) begin errs++; $display("FAIL reset_rom_ready got=%0b want=0", rom_ready); end
      checks++; if (rom_addr !== 12'h000) begin errs++; $display("FAIL reset_rom_addr got=%h want=000", rom_addr); end
      checks++; if (ins_valid !== 1'b0) begin errs++; $display("FAIL reset_ins_valid got=%0b want=0", ins_valid); end
      checks++; if (ins !== 16'h0000) begin errs++; $display("FAIL reset_ins got=%h want=0000", ins); end
      checks++; if (ins_pc !== 12'h000) begin errs++; $display("FAIL reset_ins_pc got=%h want=000", ins_pc); end
      checks++; if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted got=%0b want=0", halted); end
   endtask

   task automatic test_seq();
      exp_t e;
      int   b = 0;
      int   last = -1;
      int   viol = 0;
      do_reset();
      lat = 1;
      en_in = 1'b1;
      ins_ready = 1'b1;
      for (int a = 0; a < 4; a++) push_exp(12'(a));
      while (sbq.size() > 0 && b < 60) begin
         if (rom_ready && ins_valid) viol++;
         if (ins_valid && ins_ready) begin
            checks++;
            e = sbq.pop_front();
            if (ins !== e.i || ins_pc !== e.p) begin
               errs++; $display("FAIL seq_data got ins=%h pc=%h want ins=%h pc=%h", ins, ins_pc, e.i, e.p);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != 3) begin errs++; $display("FAIL seq_gap got=%0d want=3", cyc - last); end
            end
            last = cyc;
         end
         tick();
         b++;
      end
      checks++; if (sbq.size() != 0) begin errs++; $display("FAIL seq_timeout got=%0d pending want=0", sbq.size()); end
      checks++; if (viol != 0) begin errs++; $display("FAIL seq_ready_while_valid got=%0d want=0", viol); end
      en_in = 1'b0;
   endtask

   task automatic test_stall();
      exp_t e;
      int   b = 0;
      int   unstable = 0;
      int   bad = 0;
      bit   issued = 1'b0;
      do_reset();
      lat = 3;
      en_in = 1'b1;
      ins_ready = 1'b0;
      push_exp(12'h000);
      while (!ins_valid && b < 20) begin
         if (issued && (rom_ready !== 1'b1 || rom_addr !== 12'h000)) unstable++;
         if (rom_ready) issued = 1'b1;
         tick();
         b++;
      end
      checks++; if (ins_valid !== 1'b1) begin errs++; $display("FAIL stall_first_valid got=%0b want=1", ins_valid); end
      checks++; if (!issued || unstable != 0) begin errs++; $display("FAIL stall_req_stable got issued=%0b unstable=%0d want issued=1 unstable=0", issued, unstable); end
      for (int k = 0; k < 5; k++) begin
         if (ins_valid !== 1'b1 || ins !== 16'h1001 || ins_pc !== 12'h000 || rom_ready !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin errs++; $display("FAIL stall_hold got=%0d bad cycles want=0", bad); end
      ins_ready = 1'b1;
      if (ins_valid && ins_ready) begin
         checks++;
         e = sbq.pop_front();
         if (ins !== e.i || ins_pc !== e.p) begin
            errs++; $display("FAIL stall_data got ins=%h pc=%h want ins=%h pc=%h", ins, ins_pc, e.i, e.p);
         end
      end
      tick();
      ins_ready = 1'b0;
      checks++; if (rom_ready !== 1'b1 || rom_addr !== 12'h001) begin
         errs++; $display("FAIL stall_next_req got ready=%0b addr=%h want ready=1 addr=001", rom_ready, rom_addr);
      end
      checks++; if (sbq.size() != 0) begin errs++; $display("FAIL stall_timeout got=%0d pending want=0", sbq.size()); end
      en_in = 1'b0;
   endtask

   task automatic test_redirect();
      exp_t e;
      int   b = 0;
      bit   rd1 = 1'b0;
      bit   rd2 = 1'b0;
      do_reset();
      lat = 1;
      en_in = 1'b1;
      ins_ready = 1'b1;
      push_exp(12'h000); push_exp(12'h001);
      push_exp(12'h100); push_exp(12'h101);
      push_exp(12'h200); push_exp(12'h201);
      while (sbq.size() > 0 && b < 120) begin
         if (!rd1 && rom_ready && !rom_valid && rom_addr == 12'h002) begin
            redirect = 1'b1; redirect_pc = 12'h100; rd1 = 1'b1;
         end else if (!rd2 && rom_valid && rom_addr == 12'h102) begin
            redirect = 1'b1; redirect_pc = 12'h200; rd2 = 1'b1;
         end
         if (ins_valid && ins_ready) begin
            checks++;
            e = sbq.pop_front();
            if (ins !== e.i || ins_pc !== e.p) begin
               errs++; $display("FAIL redirect_data got ins=%h pc=%h want ins=%h pc=%h", ins, ins_pc, e.i, e.p);
            end
         end
         tick();
         b++;
      end
      checks++; if (sbq.size() != 0 || !rd1 || !rd2) begin
         errs++; $display("FAIL redirect_timeout got pending=%0d rd1=%0b rd2=%0b want 0 1 1", sbq.size(), rd1, rd2);
      end
      en_in = 1'b0;
   endtask

   task automatic test_wrap();
      exp_t e;
      int   b = 0;
      do_reset();
      lat = 1;
      redirect = 1'b1;
      redirect_pc = 12'hFFE;
      tick();
      checks++; if (rom_ready !== 1'b0) begin errs++; $display("FAIL wrap_idle_redirect got=%0b want=0", rom_ready); end
      en_in = 1'b1;
      ins_ready = 1'b1;
      push_exp(12'hFFE); push_exp(12'hFFF); push_exp(12'h000);
      while (sbq.size() > 0 && b < 40) begin
         if (ins_valid && ins_ready) begin
            checks++;
            e = sbq.pop_front();
            if (ins !== e.i || ins_pc !== e.p) begin
               errs++; $display("FAIL wrap_data got ins=%h pc=%h want ins=%h pc=%h", ins, ins_pc, e.i, e.p);
            end
         end
         tick();
         b++;
      end
      checks++; if (sbq.size() != 0) begin errs++; $display("FAIL wrap_timeout got=%0d pending want=0", sbq.size()); end
      en_in = 1'b0;
   endtask

   task automatic test_en_drop();
      exp_t e;
      int   b = 0;
      int   icnt = 0;
      int   idle_bad = 0;
      bit   dropped = 1'b0;
      bit   got1 = 1'b0;
      bit   resumed = 1'b0;
      do_reset();
      lat = 2;
      en_in = 1'b1;
      ins_ready = 1'b1;
      push_exp(12'h000); push_exp(12'h001); push_exp(12'h002);
      while (sbq.size() > 0 && b < 80) begin
         if (!dropped && rom_ready && rom_addr == 12'h001) begin
            en_in = 1'b0; dropped = 1'b1;
         end
         if (got1 && !resumed) begin
            if (rom_ready !== 1'b0 || ins_valid !== 1'b0) idle_bad++;
            icnt++;
            if (icnt == 6) begin en_in = 1'b1; resumed = 1'b1; end
         end
         if (ins_valid && ins_ready) begin
            checks++;
            e = sbq.pop_front();
            if (ins !== e.i || ins_pc !== e.p) begin
               errs++; $display("FAIL endrop_data got ins=%h pc=%h want ins=%h pc=%h", ins, ins_pc, e.i, e.p);
            end
            if (e.p == 12'h001) got1 = 1'b1;
         end
         tick();
         b++;
      end
      checks++; if (sbq.size() != 0) begin errs++; $display("FAIL endrop_timeout got=%0d pending want=0", sbq.size()); end
      checks++; if (idle_bad != 0) begin errs++; $display("FAIL endrop_idle got=%0d bad cycles want=0", idle_bad); end
      en_in = 1'b0;
   endtask

`ifdef IFETCH_HALT_EN
   task automatic test_halt();
      exp_t e;
      int   b = 0;
      int   bad = 0;
      mem[2] = 16'hF000;
      do_reset();
      lat = 1;
      en_in = 1'b1;
      ins_ready = 1'b1;
      push_exp(12'h000); push_exp(12'h001); push_exp(12'h002);
      while (sbq.size() > 0 && b < 40) begin
         if (ins_valid && ins_ready) begin
            checks++;
            e = sbq.pop_front();
            if (ins !== e.i || ins_pc !== e.p) begin
               errs++; $display("FAIL halt_data got ins=%h pc=%h want ins=%h pc=%h", ins, ins_pc, e.i, e.p);
            end
         end
         tick();
         b++;
      end
      checks++; if (sbq.size() != 0) begin errs++; $display("FAIL halt_timeout got=%0d pending want=0", sbq.size()); end
      for (int k = 0; k < 20; k++) begin
         if (halted !== 1'b1 || rom_ready !== 1'b0 || ins_valid !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin errs++; $display("FAIL halt_hold got=%0d bad cycles want=0", bad); end
      redirect = 1'b1;
      redirect_pc = 12'h000;
      push_exp(12'h000); push_exp(12'h001);
      tick();
      checks++; if (halted !== 1'b0) begin errs++; $display("FAIL halt_exit got=%0b want=0", halted); end
      b = 0;
      while (sbq.size() > 0 && b < 40) begin
         if (ins_valid && ins_ready) begin
            checks++;
            e = sbq.pop_front();
            if (ins !== e.i || ins_pc !== e.p) begin
               errs++; $display("FAIL halt_restart got ins=%h pc=%h want ins=%h pc=%h", ins, ins_pc, e.i, e.p);
            end
         end
         tick();
         b++;
      end
      checks++; if (sbq.size() != 0) begin errs++; $display("FAIL halt_restart_timeout got=%0d pending want=0", sbq.size()); end
      en_in = 1'b0;
      mem[2] = 16'h1003;
   endtask
`endif

   initial begin
      for (int a = 0; a < 4096; a++) mem[a] = 16'h1000 + 16'(a) + 16'h0001;
      test_reset();
      test_seq();
      test_stall();
      test_redirect();
      test_wrap();
      test_en_drop();
`ifdef IFETCH_HALT_EN
      test_halt();
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/cpu_ifetch.md
Name: cpu_ifetch

Overview:
- Instruction-fetch initiator for the CPU. It owns the program counter and drives the ready/valid request side of the instruction-ROM interface.
- It holds one fetched instruction in a buffer and presents it to decode over a valid/ready handshake.
- It supports a PC redirect from execute for branches and jumps.
- It sits between the core's decode stage and irom. It is the requesting counterpart of the irom responder.

Parameters:
- DWIDTH, 16, instruction word width.
- AWIDTH, 12, instruction address width (word addressed).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- en_in  input  1  fetch enable; start/continue fetching while high.
- rom_addr  output  AWIDTH  request address to irom.
- rom_ready  output  1  request strobe to irom (irom "ready").
- rom_dout  input  DWIDTH  instruction data from irom.
- rom_valid  input  1  one-cycle data-valid pulse from irom.
- redirect  input  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  input  AWIDTH  redirect target.
- ins  output  DWIDTH  buffered instruction to decode.
- ins_pc  output  AWIDTH  address of ins.
- ins_valid  output  1  ins holds a valid instruction.
- ins_ready  input  1  decode accepts ins this cycle.
- halted  output  1  see Optional Feature; tied 0 when the feature is absent.

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, rom_ready=0, rom_addr=RESET_PC, ins=0, ins_pc=0, ins_valid=0, stale=0, halted=0. Reset mid-request abandons the request; a later rom_valid is ignored while in IDLE.
- irom protocol: rom_ready and rom_addr are held stable from issue until the cycle rom_valid=1. Response latency is 1 or more cycles. At most one request is outstanding.
- IDLE:
  - en_in=1 -> REQ next cycle with rom_ready=1 and rom_addr=pc.
- REQ, on rom_valid:
  - If stale=0: latch ins=rom_dout, ins_pc=pc, set ins_valid=1, set pc=pc+1 (mod 2^AWIDTH, wraps to 0), rom_ready=0, go to HOLD.
  - If stale=1: discard the data, clear stale, and re-issue at pc (already loaded with redirect target); stay in REQ.
- HOLD:
  - ins_valid&&ins_ready -> transfer. If en_in=1, go to REQ next cycle at pc; otherwise go to IDLE.
  - Latency from accept to next rom_ready is 1 cycle. Peak throughput is one instruction per 3 cycles with 1-cycle irom.
- Redirect (highest priority, any state):
  - pc<=redirect_pc and ins_valid<=0.
  - In REQ with no rom_valid that cycle: set stale=1. rom_ready stays high with the old address until the response arrives.
  - In REQ with rom_valid in the same cycle: drop the data and re-issue at redirect_pc next cycle with stale=0.
  - In HOLD: drop the buffer and go to REQ at redirect_pc. A transfer in the same cycle still completes at the handshake; decode ignores it.
  - In IDLE: pc updated only.
- en_in falling in REQ: the outstanding request completes into HOLD; no further request is issued.
- ins, ins_pc and ins_valid are registered outputs, stable while ins_valid=1 and ins_ready=0.

Optional Feature:
- Macro: IFETCH_HALT_EN.
- Defined:
  - Adds parameter HALT_OP (4 bits, default 4'hF).
  - When a non-stale instruction with rom_dout[DWIDTH-1 -: 4]==HALT_OP is accepted by decode, the block enters HALT: halted=1, no further requests.
  - Exit only by redirect (-> REQ at target, halted=0) or rst.
- Undefined: HALT state absent, halted tied 0, opcode never inspected.

Decomposition:
- Shared package cpu_pkg:
  - State encoding typedef fetch_state_t (IDLE, REQ, HOLD, HALT).
  - HALT_OP default constant.
  - Common DWIDTH/AWIDTH defaults.
- One natural sub-module: ifetch_pc. It holds the PC register with increment/redirect/reset mux and the stale flag. The FSM and instruction buffer stay in cpu_ifetch.

Test Plan:
- Reset, then en_in=1, irom 1-cycle latency, ROM[0..3]=16'h1001..16'h1004, ins_ready=1: ins sequence 1001..1004 with ins_pc 0..3. rom_ready is never high while ins_valid=1.
- irom latency 3, ins_ready low for 5 cycles after the first valid: rom_addr/rom_ready held stable across the wait. ins=16'h1001 stable; no second request until accept.
- Redirect to 12'h100 while REQ is outstanding at addr 2: the late rom_valid data is discarded. The next ins has ins_pc=12'h100 and ins=ROM[0x100].
- pc=12'hFFF: after fetching 0xFFF, the next rom_addr is 12'h000.
- en_in dropped during REQ: the instruction is delivered, then IDLE with rom_ready=0. Re-asserting en_in resumes at the next sequential pc.
- With IFETCH_HALT_EN, ROM[2]=16'hF000: after accept, halted=1 and rom_ready stays 0 for 20 cycles. Redirect to 0 clears halted and fetching restarts at 0.
